// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter: round-robin on cyc, grant held for the whole
// cycle so bursts are never split, plus a watchdog that turns a hung slave into err.
module wb_arbiter #(
   parameter int timeout = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   // requester 0
   input  logic [31:0] wb_m0_adr,
   input  logic [31:0] wb_m0_dat_ms,
   output logic [31:0] wb_m0_dat_sm,
   input  logic [3:0]  wb_m0_sel,
   input  logic        wb_m0_we,
   input  logic        wb_m0_stb,
   input  logic        wb_m0_cyc,
   input  logic [2:0]  wb_m0_cti,
   input  logic [1:0]  wb_m0_bte,
   output logic        wb_m0_ack,
   output logic        wb_m0_err,
   output logic        wb_m0_rty,
   // requester 1
   input  logic [31:0] wb_m1_adr,
   input  logic [31:0] wb_m1_dat_ms,
   output logic [31:0] wb_m1_dat_sm,
   input  logic [3:0]  wb_m1_sel,
   input  logic        wb_m1_we,
   input  logic        wb_m1_stb,
   input  logic        wb_m1_cyc,
   input  logic [2:0]  wb_m1_cti,
   input  logic [1:0]  wb_m1_bte,
   output logic        wb_m1_ack,
   output logic        wb_m1_err,
   output logic        wb_m1_rty,
   // shared slave
   output logic [31:0] wb_s_adr,
   output logic [31:0] wb_s_dat_ms,
   input  logic [31:0] wb_s_dat_sm,
   output logic [3:0]  wb_s_sel,
   output logic        wb_s_we,
   output logic        wb_s_stb,
   output logic        wb_s_cyc,
   output logic [2:0]  wb_s_cti,
   output logic [1:0]  wb_s_bte,
   input  logic        wb_s_ack,
   input  logic        wb_s_err,
   input  logic        wb_s_rty
);

   localparam int TW = (timeout > 0) ? $clog2(timeout + 1) : 1;
   localparam logic [TW-1:0] TLAST = TW'((timeout > 0) ? timeout - 1 : 0);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t          state_q, state_d;
   logic            last_q, last_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            to_err_q, to_err_d;
   logic            own_cyc, own_stb, stall;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (wb_m0_cyc && wb_m1_cyc) state_d = last_q ? GNT0 : GNT1;
            else if (wb_m0_cyc)         state_d = GNT0;
            else if (wb_m1_cyc)         state_d = GNT1;
         end
         GNT0:    if (!wb_m0_cyc) state_d = wb_m1_cyc ? GNT1 : IDLE;
         GNT1:    if (!wb_m1_cyc) state_d = wb_m0_cyc ? GNT0 : IDLE;
         default: state_d = IDLE;
      endcase

      last_d = last_q;
      if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
      if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;
   end

   always_comb begin
      own_cyc = 1'b0;
      own_stb = 1'b0;
      case (state_q)
         GNT0:    begin own_cyc = wb_m0_cyc; own_stb = wb_m0_stb; end
         GNT1:    begin own_cyc = wb_m1_cyc; own_stb = wb_m1_stb; end
         default: begin own_cyc = 1'b0;      own_stb = 1'b0;      end
      endcase
   end

   // A slave ack on the final stall cycle beats the timeout; any break in the stall restarts the count.
   always_comb begin
      tcnt_d   = '0;
      to_err_d = 1'b0;
      stall    = own_cyc & own_stb & ~wb_s_ack & ~wb_s_err & ~to_err_q & (state_d == state_q);
      if (timeout != 0 && stall) begin
         if (tcnt_q == TLAST) to_err_d = 1'b1;
         else                 tcnt_d   = tcnt_q + TW'(1);
      end
   end

   always_comb begin
      wb_s_adr    = wb_m0_adr;
      wb_s_dat_ms = wb_m0_dat_ms;
      wb_s_sel    = wb_m0_sel;
      wb_s_we     = wb_m0_we;
      wb_s_cti    = wb_m0_cti;
      wb_s_bte    = wb_m0_bte;
      wb_s_cyc    = 1'b0;
      wb_s_stb    = 1'b0;
      wb_m0_ack   = 1'b0;
      wb_m0_err   = 1'b0;
      wb_m0_rty   = 1'b0;
      wb_m1_ack   = 1'b0;
      wb_m1_err   = 1'b0;
      wb_m1_rty   = 1'b0;
      case (state_q)
         GNT0: begin
            wb_s_cyc  = wb_m0_cyc;
            wb_s_stb  = wb_m0_cyc & wb_m0_stb & ~to_err_q;
            wb_m0_ack = wb_s_ack & ~to_err_q;
            wb_m0_err = wb_s_err | to_err_q;
            wb_m0_rty = wb_s_rty & ~to_err_q;
         end
         GNT1: begin
            wb_s_adr    = wb_m1_adr;
            wb_s_dat_ms = wb_m1_dat_ms;
            wb_s_sel    = wb_m1_sel;
            wb_s_we     = wb_m1_we;
            wb_s_cti    = wb_m1_cti;
            wb_s_bte    = wb_m1_bte;
            wb_s_cyc    = wb_m1_cyc;
            wb_s_stb    = wb_m1_cyc & wb_m1_stb & ~to_err_q;
            wb_m1_ack   = wb_s_ack & ~to_err_q;
            wb_m1_err   = wb_s_err | to_err_q;
            wb_m1_rty   = wb_s_rty & ~to_err_q;
         end
         default: ;
      endcase
   end

   assign wb_m0_dat_sm = wb_s_dat_sm;
   assign wb_m1_dat_sm = wb_s_dat_sm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         tcnt_q   <= '0;
         to_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         tcnt_q   <= tcnt_d;
         to_err_q <= to_err_d;
      end
   end

endmodule
